// File: rtl/aes_pkg.sv
// Shared AES key-expansion constants: S-box, round constants, Nk/Nr helpers and FSM states.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_FLUSH
  } ks_state_t;

  // Row-major FIPS-197 S-box; byte x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  // rc_j for j = 1..10; other indices never reach the datapath.
  function automatic logic [7:0] rcon(input logic [3:0] j);
    logic [7:0] rc;
    case (j)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES key expansion, one word per cycle, round keys out on a valid/ready port.
// Optional round-key store enabled by defining KS_RKMEM_EN.
module key_schedule_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [3:0]          rk_idx,
  output logic                done,
  input  logic [3:0]          rk_raddr,
  output logic [127:0]        rk_rdata
);

  localparam int NK     = nk_of(KEY_BITS);
  localparam int NR     = nr_of(KEY_BITS);
  localparam int NWORDS = 4 * (NR + 1);

  ks_state_t   state, state_nxt;
  logic [31:0] win [NK];
  logic [31:0] coll [4];
  logic [1:0]  coll_cnt;
  logic        coll_full;
  logic [5:0]  i;
  logic [2:0]  pos;
  logic [3:0]  rcon_j;
  logic [3:0]  next_idx;

  logic        accept, out_free, gen, hs_last, first_pass;
  logic [31:0] last_w, sw_in, sw_out, temp, w_new;

  assign accept     = (state == ST_IDLE) && start;
  assign out_free   = !rk_valid || rk_ready;
  // Stall only when the next round is already parked and the output is blocked.
  assign gen        = (state == ST_EXPAND) && !(coll_full && !out_free);
  assign hs_last    = (state == ST_FLUSH) && rk_valid && rk_ready && (rk_idx == 4'(NR));
  assign busy       = (state != ST_IDLE);
  assign first_pass = (i < 6'(NK));

  assign last_w = win[NK-1];
  assign sw_in  = (pos == 3'd0) ? {last_w[23:0], last_w[31:24]} : last_w;

  subword u_subword (
    .word_in  (sw_in),
    .word_out (sw_out)
  );

  always_comb begin
    temp = last_w;
    if (pos == 3'd0) begin
      temp = sw_out ^ {rcon(rcon_j), 24'h0};
    end else if (NK == 8 && pos == 3'd4) begin
      temp = sw_out;
    end
  end

  // The window cycles through the key words unchanged on the first pass.
  assign w_new = first_pass ? win[0] : (win[0] ^ temp);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_EXPAND;
      ST_EXPAND: if (gen && i == 6'(NWORDS - 1)) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (hs_last) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) win[k] <= '0;
      for (int k = 0; k < 4; k++) coll[k] <= '0;
      coll_cnt  <= '0;
      coll_full <= 1'b0;
      i         <= '0;
      pos       <= '0;
      rcon_j    <= '0;
      next_idx  <= '0;
      rk_valid  <= 1'b0;
      rk_data   <= '0;
      rk_idx    <= '0;
      done      <= 1'b0;
    end else begin
      done <= hs_last;
      if (accept) begin
        for (int k = 0; k < NK; k++) win[k] <= key_in[KEY_BITS-1-32*k -: 32];
        coll_cnt  <= '0;
        coll_full <= 1'b0;
        i         <= '0;
        pos       <= '0;
        rcon_j    <= '0;
        next_idx  <= '0;
        rk_valid  <= 1'b0;
        rk_idx    <= '0;
      end else begin
        if (gen) begin
          for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
          win[NK-1]      <= w_new;
          coll[coll_cnt] <= w_new;
          coll_cnt       <= coll_cnt + 2'd1;
          i              <= i + 6'd1;
          if (pos == 3'(NK - 1)) begin
            pos    <= '0;
            rcon_j <= rcon_j + 4'd1;
          end else begin
            pos <= pos + 3'd1;
          end
        end

        if (coll_full && out_free) begin
          rk_data   <= {coll[0], coll[1], coll[2], coll[3]};
          rk_valid  <= 1'b1;
          rk_idx    <= next_idx;
          next_idx  <= next_idx + 4'd1;
          coll_full <= 1'b0;
        end else if (gen && coll_cnt == 2'd3 && out_free) begin
          rk_data  <= {coll[0], coll[1], coll[2], w_new};
          rk_valid <= 1'b1;
          rk_idx   <= next_idx;
          next_idx <= next_idx + 4'd1;
        end else begin
          if (gen && coll_cnt == 2'd3) coll_full <= 1'b1;
          if (rk_valid && rk_ready)    rk_valid  <= 1'b0;
        end
      end
    end
  end

`ifdef KS_RKMEM_EN
  logic [127:0] rk_mem [15];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 15; k++) rk_mem[k] <= '0;
    end else if (rk_valid && rk_ready) begin
      rk_mem[rk_idx] <= rk_data;
    end
  end

  assign rk_rdata = (rk_raddr <= 4'(NR)) ? rk_mem[rk_raddr] : '0;
`else
  logic unused_raddr;
  assign unused_raddr = ^rk_raddr;
  assign rk_rdata     = '0;
`endif

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed bench for key_schedule_iter at 128/192/256-bit keys with a round-key scoreboard.
module tb_key_schedule_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        start_v, ready_v, busy_v, valid_v, done_v;
  logic [127:0]      key128;
  logic [191:0]      key192;
  logic [255:0]      key256;
  logic [2:0][127:0] data_v, rdata_v;
  logic [2:0][3:0]   idx_v;
  logic [3:0]        raddr;

  key_schedule_iter #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key_in(key128), .busy(busy_v[0]),
    .rk_valid(valid_v[0]), .rk_ready(ready_v[0]), .rk_data(data_v[0]), .rk_idx(idx_v[0]),
    .done(done_v[0]), .rk_raddr(raddr), .rk_rdata(rdata_v[0]));

  key_schedule_iter #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key_in(key192), .busy(busy_v[1]),
    .rk_valid(valid_v[1]), .rk_ready(ready_v[1]), .rk_data(data_v[1]), .rk_idx(idx_v[1]),
    .done(done_v[1]), .rk_raddr(raddr), .rk_rdata(rdata_v[1]));

  key_schedule_iter #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key_in(key256), .busy(busy_v[2]),
    .rk_valid(valid_v[2]), .rk_ready(ready_v[2]), .rk_data(data_v[2]), .rk_idx(idx_v[2]),
    .done(done_v[2]), .rk_raddr(raddr), .rk_rdata(rdata_v[2]));

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
    logic [127:0] mask;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [127:0] data, input logic [127:0] mask);
    exp_t e;
    e.idx = 4'(idx); e.data = data; e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic push_fips();
    for (int r = 0; r < 11; r++) push(r, fips_rk[r], '1);
  endtask

  // Consumes one full expansion on instance k; cycle 0 is the cycle after the accept edge.
  task automatic run(input int k, input bit rnd, input bit timing);
    int c, ndone, done_c, nr;
    bit stalled;
    logic [127:0] held;
    logic [3:0] held_idx;
    exp_t e;
    nr = (k == 0) ? 10 : (k == 1) ? 12 : 14;
    c = 0; ndone = 0; done_c = 0; stalled = 1'b0; held = '0; held_idx = '0;
    chk("busy_c0", 128'(busy_v[k]), 128'd1);
    while (c < 600 && !(ndone > 0 && c >= done_c + 4)) begin
      ready_v[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (timing && c == 10) begin
        start_v[k] = 1'b1;
        key128 = '0;
      end else begin
        start_v[k] = 1'b0;
      end
      if (stalled) begin
        chk("stall_data", data_v[k], held);
        chk("stall_idx", 128'(idx_v[k]), 128'(held_idx));
      end
      if (valid_v[k] && ready_v[k]) begin
        chk("sb_nonempty", 128'(sb.size() > 0), 128'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rk_idx", 128'(idx_v[k]), 128'(e.idx));
          chk("rk_data", data_v[k] & e.mask, e.data & e.mask);
          if (timing) chk("rk_cycle", 128'(c), 128'(4 + 4 * int'(e.idx)));
        end
      end
      stalled = valid_v[k] && !ready_v[k];
      held = data_v[k];
      held_idx = idx_v[k];
      if (done_v[k]) begin
        ndone++;
        done_c = c;
        if (timing) chk("done_cycle", 128'(c), 128'(4 * (nr + 1) + 1));
      end
      @(posedge clk); #1;
      c++;
    end
    start_v[k] = 1'b0;
    ready_v[k] = 1'b0;
    chk("done_once", 128'(ndone), 128'd1);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    chk("busy_end", 128'(busy_v[k]), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_v = '0; ready_v = '0; raddr = '0;
    key128 = '0; key192 = '0; key256 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy_v[0]), 128'd0);
    chk("rst_valid", 128'(valid_v), 128'd0);
    chk("rst_done", 128'(done_v[0]), 128'd0);
    chk("rst_data", data_v[0], '0);
    chk("rst_idx", 128'(idx_v[0]), 128'd0);
    chk("rst_rdata", rdata_v[0], '0);

    // Start on the very first edge out of reset; stray start mid-run must be ignored.
    rst_n = 1'b1;
    key128 = FIPS_KEY;
    start_v[0] = 1'b1;
    push_fips();
    @(posedge clk); #1;
    run(0, 1'b0, 1'b1);

    raddr = 4'd10; #1;
`ifdef KS_RKMEM_EN
    chk("mem_r10", rdata_v[0], fips_rk[10]);
    raddr = 4'd3; #1;
    chk("mem_r3", rdata_v[0], fips_rk[3]);
`else
    chk("mem_r10", rdata_v[0], '0);
    raddr = 4'd3; #1;
    chk("mem_r3", rdata_v[0], '0);
`endif
    raddr = 4'd15; #1;
    chk("mem_r15", rdata_v[0], '0);

    // Random backpressure on the same vector.
    key128 = FIPS_KEY;
    start_v[0] = 1'b1;
    push_fips();
    @(posedge clk); #1;
    run(0, 1'b1, 1'b0);

    // Abort a zero-key expansion at cycle 20, then restart with the FIPS key.
    key128 = '0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    ready_v[0] = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    chk("abort_pre_valid", 128'(valid_v[0]), 128'd1);
    chk("abort_pre_idx", 128'(idx_v[0]), 128'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", 128'(busy_v[0]), 128'd0);
    chk("abort_valid", 128'(valid_v[0]), 128'd0);
    chk("abort_data", data_v[0], '0);
    chk("abort_idx", 128'(idx_v[0]), 128'd0);
    ready_v[0] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      chk("abort_quiet", 128'({valid_v[0], done_v[0]}), 128'd0);
    end
    key128 = FIPS_KEY;
    start_v[0] = 1'b1;
    push_fips();
    @(posedge clk); #1;
    run(0, 1'b0, 1'b0);

    // 192-bit key: round 0, upper half of round 1, final round checked in full.
    key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    start_v[1] = 1'b1;
    push(0, 128'h8e73b0f7da0e6452c810f32b809079e5, '1);
    push(1, {64'h62f8ead2522c6b7b, 64'h0}, {64'hffffffffffffffff, 64'h0});
    for (int r = 2; r < 12; r++) push(r, '0, '0);
    push(12, 128'he98ba06f448c773c8ecc720401002202, '1);
    @(posedge clk); #1;
    run(1, 1'b1, 1'b0);

    // 256-bit key: rounds 0 and 1 are the key itself.
    key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    start_v[2] = 1'b1;
    push(0, 128'h603deb1015ca71be2b73aef0857d7781, '1);
    push(1, 128'h1f352c073b6108d72d9810a30914dff4, '1);
    for (int r = 2; r < 14; r++) push(r, '0, '0);
    push(14, 128'hfe4890d1e6188d0b046df344706c631e, '1);
    @(posedge clk); #1;
    run(2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_schedule_iter.md
KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

Interface
REQ-001 Parameter KEY_BITS, default 128, AES key length; legal values 128, 192, 256 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to expand key_in; accepted only when busy=0.
REQ-005 key_in  input  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 32] are word w[0].
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 rk_valid  output  1  rk_data holds a complete round key.
REQ-008 rk_ready  input  1  consumer accepts rk_data when rk_valid=1.
REQ-009 rk_data  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}; w[4r] in [127:96].
REQ-010 rk_idx  output  4  round number r of rk_data, 0..Nr.
REQ-011 done  output  1  one-cycle pulse after the round Nr handshake.
REQ-012 rk_raddr  input  4  read address of the stored round key (see Configuration).
REQ-013 rk_rdata  output  128  stored round key at rk_raddr, combinational.

Function
REQ-014 Nk=KEY_BITS/32, Nr=Nk+6; total words 4*(Nr+1) = 44/52/60.
REQ-015 FSM states IDLE, EXPAND, FLUSH; IDLE->EXPAND on start; EXPAND->FLUSH after last word is generated; FLUSH->IDLE on round Nr handshake (done pulses that edge).
REQ-016 Start accept edge latches key_in into an Nk-word sliding window and clears word counter i and rk_idx.
REQ-017 EXPAND produces exactly one word w[i] per unstalled cycle, in order i=0,1,2,...
REQ-018 i<Nk: w[i]=key word i; otherwise temp=w[i-1]; if i mod Nk==0 temp=SubWord(RotWord(temp))^Rcon[i/Nk]; else if Nk==8 and i mod Nk==4 temp=SubWord(temp); w[i]=w[i-Nk]^temp.
REQ-019 RotWord is a one-byte left rotate; Rcon[j] = {rc_j,24'h0}, rc = 01,02,04,08,10,20,40,80,1b,36.
REQ-020 Words collect in a 4-word output buffer; rk_valid rises the cycle after the 4th word of a round is written.
REQ-021 Handshake: transfer when rk_valid&&rk_ready; rk_data/rk_idx stable while rk_valid=1 and rk_ready=0.
REQ-022 Backpressure: while rk_valid=1 and rk_ready=0 and the next round's 4 words are complete, generation stalls; no word lost or duplicated.
REQ-023 With rk_ready held high, round r is valid in cycle 4+4r after the accept cycle (cycle 0); done in cycle 4*(Nr+1)+1.
REQ-024 Simultaneous handshake and new-round completion in one cycle: buffer reloads, rk_valid stays high, rk_idx increments.
REQ-025 start while busy=1 is ignored; key_in changes while busy have no effect.

Reset
REQ-026 rst_n=0 at a rising edge: FSM->IDLE, busy=0, rk_valid=0, done=0, rk_data=0, rk_idx=0, i=0, window cleared, including mid-expansion (expansion aborted, no further rk_valid).
REQ-027 First start is honoured on the first edge with rst_n=1.

Configuration
REQ-028 Macro KS_RKMEM_EN: defined -> 15x128 round-key store written at each handshake (entry r), rk_rdata=store[rk_raddr], store cleared on reset, addr>Nr reads 0.
REQ-029 KS_RKMEM_EN undefined -> no store instantiated, rk_rdata tied to 0, rk_raddr unused; all other behaviour identical.

Structure
REQ-030 Shared package aes_pkg holds Rcon table, SBOX constant, Nk/Nr derivation functions, FSM state typedef.
REQ-031 One sub-module subword (4 parallel S-box lookups, 32 in/32 out, combinational); one instance.

Verification
REQ-032 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_idx=10 rk_data d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 44, done cycle 45.
REQ-033 KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx=12 rk_data e98ba06f448c773c8ecc720401002202.
REQ-034 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx=14 rk_data fe4890d1e6188d0b046df344706c631e.
REQ-035 128-bit vector, rk_ready randomly low 50% -> identical 11-key sequence, rk_data stable during stalls, done once.
REQ-036 rst_n=0 at cycle 20 of expansion, then start with new key -> no rk_valid before restart; new sequence correct from rk_idx=0.
REQ-037 KS_RKMEM_EN defined, after REQ-032 run, rk_raddr=10 -> rk_rdata d014f9a8c9ee2589e13f0cc8b6630ca6; undefined -> 0.
